// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative 32-bit MIPS multiply/divide unit owning HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [31:0] r_rs_orig;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic        w_accept;
    logic [31:0] w_add;
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Unsigned ops (op[0]=1) never flag a sign; |0x80000000| wraps to itself.
    always_comb begin
        w_rs_neg = ~op[0] & rs_data[31];
        w_rt_neg = ~op[0] & rt_data[31];
        w_rs_mag = w_rs_neg ? (~rs_data + 32'd1) : rs_data;
        w_rt_mag = w_rt_neg ? (~rt_data + 32'd1) : rt_data;
        w_accept = start & ((r_state == S_IDLE) | (r_state == S_FIX));
    end

    // Multiply: r_acc = {partial high, remaining multiplier bits}, shift right.
    always_comb begin
        w_add      = r_acc[0] ? r_opnd : 32'd0;
        w_sum      = {1'b0, r_acc[63:32]} + {1'b0, w_add};
        w_mul_next = {w_sum, r_acc[31:1]};
    end

    // Divide: r_acc = {remainder, dividend/quotient}, shift left one bit.
    always_comb begin
        w_shift = r_acc[63:31];
        w_diff  = w_shift - {1'b0, r_opnd};
        if (w_diff[32]) begin
            w_div_next = {w_shift[31:0], r_acc[30:0], 1'b0};
        end else begin
            w_div_next = {w_diff[31:0], r_acc[30:0], 1'b1};
        end
    end

    always_comb begin
        w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
        w_quo  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        if (!r_is_div) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else if (r_dz) begin
            w_res_hi = r_rs_orig;
            w_res_lo = 32'hFFFF_FFFF;
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_rs_orig <= 32'd0;
            r_opnd    <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!start) begin
                        if (mthi) r_hi <= rs_data;
                        if (mtlo) r_lo <= rs_data;
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Launch overrides the IDLE/FIX updates above so FIX can chain.
            if (w_accept) begin
                r_is_div  <= op[1];
                r_neg_q   <= w_rs_neg ^ w_rt_neg;
                r_neg_r   <= op[1] & w_rs_neg;
                r_dz      <= op[1] & (rt_data == 32'd0);
                r_rs_orig <= rs_data;
                r_opnd    <= op[1] ? w_rt_mag : w_rs_mag;
                r_acc     <= {32'd0, (op[1] ? w_rs_mag : w_rt_mag)};
                r_cnt     <= 5'd0;
                r_state   <= S_CALC;
                r_busy    <= 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire
